// File: rtl/stdp_update_scheduler.sv
// Sweeps one shared STDP update unit over NUM_SYN weights in a single-port memory; shares the port with a host.
// Latency: 4 cycles per synapse, done 4*NUM_SYN+1 cycles after step_start; host read data 1 cycle after grant.
// Backpressure: host requests stall (host_gnt=0) while a sweep runs; step_start while busy is dropped with step_overrun.
module stdp_update_scheduler #(
    parameter int buffer_size = 32,
    parameter int NUM_SYN     = 64,
    parameter int ADDR_W      = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step_start,
    input  logic                     learning_phase,
    input  logic [NUM_SYN-1:0]       pre_spikes,
    input  logic [buffer_size-1:0]   V_mem_post,
    input  logic [buffer_size/2-1:0] Ca_post,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rd_en,
    input  logic [buffer_size-1:0]   mem_rd_data,
    output logic                     mem_wr_en,
    output logic [buffer_size-1:0]   mem_wr_data,
    output logic                     upd_learning_phase,
    output logic                     upd_A_pre,
    output logic [buffer_size-1:0]   upd_W_previous,
    output logic [buffer_size-1:0]   upd_V_mem_post,
    output logic [buffer_size/2-1:0] upd_Ca_post,
    input  logic [buffer_size-1:0]   upd_W_new,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [ADDR_W-1:0]        host_addr,
    input  logic [buffer_size-1:0]   host_wdata,
    output logic                     host_gnt,
    output logic [buffer_size-1:0]   host_rdata,
    output logic                     host_rvalid,
    output logic                     busy,
    output logic                     done,
    output logic                     step_overrun
);

    typedef enum logic [2:0] {IDLE, RD, LOAD, UPD, WR} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SYN - 1);

    state_t                   state;
    logic [ADDR_W-1:0]        idx;
    logic [buffer_size-1:0]   w_reg;
    logic [NUM_SYN-1:0]       spikes_lat;
    logic [buffer_size-1:0]   v_lat;
    logic [buffer_size/2-1:0] ca_lat;

    logic sweep_rd;
    logic sweep_wr;
    logic host_wr_gnt;
    logic host_rd_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            w_reg        <= '0;
            spikes_lat   <= '0;
            v_lat        <= '0;
            ca_lat       <= '0;
            done         <= 1'b0;
            step_overrun <= 1'b0;
            host_rvalid  <= 1'b0;
        end else begin
            done         <= 1'b0;
            step_overrun <= 1'b0;
            host_rvalid  <= host_rd_gnt;
            if (step_start && state != IDLE)
                step_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (step_start) begin
                        spikes_lat <= pre_spikes;
                        v_lat      <= V_mem_post;
                        ca_lat     <= Ca_post;
                        if (learning_phase) begin
                            idx   <= '0;
                            state <= RD;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RD:   state <= LOAD;
                LOAD: begin
                    w_reg <= mem_rd_data;
                    state <= UPD;
                end
                UPD:  state <= WR;
                WR: begin
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Host is gated by reset so every output reads zero while reset is held.
    assign host_gnt    = reset & host_req & (state == IDLE) & ~step_start;
    assign host_wr_gnt = host_gnt & host_we;
    assign host_rd_gnt = host_gnt & ~host_we;
    assign host_rdata  = host_rvalid ? mem_rd_data : '0;

    assign sweep_rd = (state == RD);
    assign sweep_wr = (state == WR);
    assign busy     = (state != IDLE);

    assign mem_rd_en   = sweep_rd | host_rd_gnt;
    assign mem_wr_en   = sweep_wr | host_wr_gnt;
    assign mem_addr    = (sweep_rd | sweep_wr) ? idx : (host_gnt ? host_addr : '0);
    assign mem_wr_data = sweep_wr ? upd_W_new : (host_wr_gnt ? host_wdata : '0);

    // Data inputs stay stable through WR; only the enable drops so the unit's registers clear.
    assign upd_learning_phase = (state == UPD);
    assign upd_A_pre          = spikes_lat[idx];
    assign upd_W_previous     = w_reg;
    assign upd_V_mem_post     = v_lat;
    assign upd_Ca_post        = ca_lat;

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Bench for stdp_update_scheduler: behavioural weight memory and update-unit stub with queue-based scoreboard.
module tb_stdp_update_scheduler;

    localparam int BS = 32;
    localparam int N  = 64;
    localparam int AW = 6;
    localparam logic [BS-1:0] VTH     = 32'h0080_0000;
    localparam logic [BS-1:0] V_HIGH  = 32'h0100_0000;
    localparam logic [BS-1:0] V_LOW   = 32'h0010_0000;
    localparam logic [BS-1:0] W_INIT  = 32'h0010_0000;
    localparam logic [BS-1:0] W_POT   = 32'h0010_CCD0;
    localparam logic [BS-1:0] W_DEP   = 32'h000F_3330;
    localparam logic [BS-1:0] W_POT2  = 32'h0011_99A0;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            step_start = 1'b0;
    logic            learning_phase = 1'b0;
    logic [N-1:0]    pre_spikes = '0;
    logic [BS-1:0]   V_mem_post = '0;
    logic [BS/2-1:0] Ca_post = '0;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd_en;
    logic [BS-1:0]   mem_rd_data = '0;
    logic            mem_wr_en;
    logic [BS-1:0]   mem_wr_data;
    logic            upd_learning_phase;
    logic            upd_A_pre;
    logic [BS-1:0]   upd_W_previous;
    logic [BS-1:0]   upd_V_mem_post;
    logic [BS/2-1:0] upd_Ca_post;
    logic [BS-1:0]   upd_W_new;
    logic            host_req = 1'b0;
    logic            host_we = 1'b0;
    logic [AW-1:0]   host_addr = '0;
    logic [BS-1:0]   host_wdata = '0;
    logic            host_gnt;
    logic [BS-1:0]   host_rdata;
    logic            host_rvalid;
    logic            busy;
    logic            done;
    logic            step_overrun;

    stdp_update_scheduler #(.buffer_size(BS), .NUM_SYN(N), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .step_start(step_start), .learning_phase(learning_phase),
        .pre_spikes(pre_spikes), .V_mem_post(V_mem_post), .Ca_post(Ca_post),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .upd_learning_phase(upd_learning_phase), .upd_A_pre(upd_A_pre),
        .upd_W_previous(upd_W_previous), .upd_V_mem_post(upd_V_mem_post),
        .upd_Ca_post(upd_Ca_post), .upd_W_new(upd_W_new),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .busy(busy), .done(done), .step_overrun(step_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port weight memory, one-cycle read latency.
    logic [BS-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Update-unit stub: delta registered while learning_phase is high, cleared otherwise.
    logic [BS-1:0] delta = '0;
    always @(posedge clk) begin
        if (!upd_learning_phase)
            delta <= '0;
        else if (!upd_A_pre)
            delta <= '0;
        else if (upd_V_mem_post > VTH && upd_Ca_post >= 16'h0600)
            delta <= 32'h0000_CCD0;
        else if (upd_V_mem_post <= VTH && upd_Ca_post < 16'h0600)
            delta <= 32'hFFFF_3330;
        else
            delta <= '0;
    end
    assign upd_W_new = upd_W_previous + delta;

    typedef struct { logic [AW-1:0] a; logic [BS-1:0] d; } wr_t;
    typedef struct { int c; logic [BS-1:0] d; } rd_t;
    wr_t exp_wr[$];
    rd_t exp_rd[$];
    int  exp_done[$];
    int  exp_ovr[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [BS-1:0] got, input logic [BS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge clk) begin
        if (mem_wr_en && busy) begin
            if (exp_wr.size() == 0) fail_now("unexpected_sweep_write");
            else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("sweep_wr_addr", BS'(mem_addr), BS'(w.a));
                check("sweep_wr_data", mem_wr_data, w.d);
            end
        end
        if (done) begin
            if (exp_done.size() == 0) fail_now("unexpected_done");
            else begin
                check("done_cycle", cyc, exp_done.pop_front());
                check("busy_at_done", BS'(busy), 0);
            end
        end
        if (step_overrun) begin
            if (exp_ovr.size() == 0) fail_now("unexpected_overrun");
            else check("overrun_cycle", cyc, exp_ovr.pop_front());
        end
        if (host_rvalid) begin
            if (exp_rd.size() == 0) fail_now("unexpected_rvalid");
            else begin
                rd_t r;
                r = exp_rd.pop_front();
                check("rvalid_cycle", cyc, r.c);
                check("host_rdata", host_rdata, r.d);
            end
        end
        if (busy && host_req)
            check("gnt_while_busy", BS'(host_gnt), 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_addr"}, BS'(mem_addr), 0);
        check({tag, "_mem_rd_en"}, BS'(mem_rd_en), 0);
        check({tag, "_mem_wr_en"}, BS'(mem_wr_en), 0);
        check({tag, "_mem_wr_data"}, mem_wr_data, 0);
        check({tag, "_upd_lp"}, BS'(upd_learning_phase), 0);
        check({tag, "_upd_a_pre"}, BS'(upd_A_pre), 0);
        check({tag, "_upd_w_prev"}, upd_W_previous, 0);
        check({tag, "_upd_v"}, upd_V_mem_post, 0);
        check({tag, "_upd_ca"}, BS'(upd_Ca_post), 0);
        check({tag, "_host_gnt"}, BS'(host_gnt), 0);
        check({tag, "_host_rvalid"}, BS'(host_rvalid), 0);
        check({tag, "_host_rdata"}, host_rdata, 0);
        check({tag, "_busy"}, BS'(busy), 0);
        check({tag, "_done"}, BS'(done), 0);
        check({tag, "_overrun"}, BS'(step_overrun), 0);
    endtask

    task automatic preload(input logic [BS-1:0] val);
        for (int i = 0; i < N; i++) begin
            host_req = 1'b1; host_we = 1'b1; host_addr = AW'(i); host_wdata = val;
            tick();
        end
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic issue_step(input logic lp, input logic [N-1:0] sp, input logic [BS-1:0] v,
                              input logic [BS/2-1:0] ca, output int t0);
        step_start = 1'b1; learning_phase = lp; pre_spikes = sp; V_mem_post = v; Ca_post = ca;
        t0 = cyc;
    endtask

    task automatic push_sweep(input int count, input logic [BS-1:0] even_v, input logic [BS-1:0] odd_v,
                              input int split, input logic [BS-1:0] low_v);
        for (int i = 0; i < count; i++) begin
            wr_t w;
            w.a = AW'(i);
            if (i < split) w.d = low_v;
            else w.d = (i % 2 == 0) ? even_v : odd_v;
            exp_wr.push_back(w);
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 400 && exp_done.size() != 0; k++) tick();
        if (exp_done.size() != 0) begin
            fail_now("done_timeout");
            exp_done.delete();
        end
    endtask

    task automatic wait_gnt(output int gc);
        gc = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (host_gnt) begin gc = cyc; break; end
        end
        if (gc < 0) fail_now("gnt_timeout");
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    task automatic host_read_seq(input logic [AW-1:0] a, input logic [BS-1:0] exp_v);
        rd_t r;
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        r.c = cyc + 1; r.d = exp_v;
        exp_rd.push_back(r);
        tick();
    endtask

    initial begin
        int t0;
        int gc;
        rd_t r;
        #3;
        check_all_zero("reset");
        tick();
        reset = 1'b1;
        tick();

        // Potentiation sweep, host read of addr 5 held across it.
        preload(W_INIT);
        issue_step(1'b1, {N{1'b1}}, V_HIGH, 16'h0800, t0);
        push_sweep(N, W_POT, W_POT, 0, '0);
        exp_done.push_back(t0 + 4*N + 1);
        tick();
        step_start = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'd5;
        r.c = t0 + 4*N + 2; r.d = W_POT;
        exp_rd.push_back(r);
        wait_gnt(gc);
        check("held_read_gnt_cycle", gc, t0 + 4*N + 1);
        wait_done();
        host_read_seq(6'd0, W_POT);
        host_read_seq(6'd31, W_POT);
        host_read_seq(6'd63, W_POT);
        host_req = 1'b0;
        tick();

        // learning_phase low: immediate done, no memory traffic.
        issue_step(1'b0, {N{1'b1}}, V_HIGH, 16'h0800, t0);
        exp_done.push_back(t0 + 1);
        tick();
        step_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("nolearn_busy", BS'(busy), 0);
            check("nolearn_wr_en", BS'(mem_wr_en), 0);
            check("nolearn_rd_en", BS'(mem_rd_en), 0);
        end
        tick();

        // Depression on even synapses, host read collides with step_start, overrun at cycle 10.
        preload(W_INIT);
        issue_step(1'b1, {(N/2){2'b01}}, V_LOW, 16'h0400, t0);
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'd2;
        push_sweep(N, W_DEP, W_INIT, 0, '0);
        exp_done.push_back(t0 + 4*N + 1);
        r.c = t0 + 4*N + 2; r.d = W_DEP;
        exp_rd.push_back(r);
        @(negedge clk);
        check("step_beats_host", BS'(host_gnt), 0);
        tick();
        step_start = 1'b0;
        while (cyc < t0 + 10) tick();
        issue_step(1'b1, '0, V_HIGH, 16'h0800, gc);
        exp_ovr.push_back(t0 + 11);
        tick();
        step_start = 1'b0;
        wait_gnt(gc);
        check("collide_gnt_cycle", gc, t0 + 4*N + 1);
        wait_done();
        host_read_seq(6'd1, W_INIT);
        host_read_seq(6'd62, W_DEP);
        host_req = 1'b0;
        tick();

        // Reset in cycle 50 of a sweep, then a full restart.
        preload(W_INIT);
        issue_step(1'b1, {N{1'b1}}, V_HIGH, 16'h0800, t0);
        push_sweep(12, W_POT, W_POT, 0, '0);
        tick();
        step_start = 1'b0;
        while (cyc < t0 + 50) tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'd3;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        tick();
        tick();
        host_req = 1'b0;
        reset = 1'b1;
        tick();
        issue_step(1'b1, {N{1'b1}}, V_HIGH, 16'h0800, t0);
        push_sweep(N, W_POT, W_POT, 12, W_POT2);
        exp_done.push_back(t0 + 4*N + 1);
        tick();
        step_start = 1'b0;
        wait_done();
        host_read_seq(6'd0, W_POT2);
        host_read_seq(6'd11, W_POT2);
        host_read_seq(6'd12, W_POT);
        host_read_seq(6'd40, W_POT);
        host_req = 1'b0;
        tick();
        tick();

        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_reads", exp_rd.size(), 0);
        check("leftover_done", exp_done.size(), 0);
        check("leftover_overrun", exp_ovr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
